// File: rtl/osd_textwriter.sv
// Character-stream writer for the 32x8 OSD text buffer: cursor tracking, CR/LF/BS/FF handling
// and row/screen clear loops. Define OSD_TEXTWRITER_INVERSE_EN to enable SO/SI inverse video.
module osd_textwriter #(
    parameter int          WINDOW_W = 32,
    parameter int          WINDOW_H = 8,
    parameter logic [7:0]  BLANK    = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       wren,
    output logic [4:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       busy
);

    localparam logic [4:0] LAST_COL = 5'(WINDOW_W - 1);
    localparam logic [2:0] LAST_ROW = 3'(WINDOW_H - 1);

    typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

    state_t     state_q, state_d;
    logic [4:0] cursor_x_q, cursor_x_d;
    logic [2:0] cursor_y_q, cursor_y_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic [7:0] address_q, address_d;
    logic [7:0] data_q, data_d;
    logic       wren_q, wren_d;
    logic       newline;
    logic [7:0] blankData;
`ifdef OSD_TEXTWRITER_INVERSE_EN
    logic       inv_q, inv_d;
    assign blankData = {1'b0, BLANK[6:0]};
`else
    assign blankData = BLANK;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
            clr_cnt_q  <= '0;
            address_q  <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
`ifdef OSD_TEXTWRITER_INVERSE_EN
            inv_q      <= 1'b0;
`endif
        end else if (ce) begin
            state_q    <= state_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            clr_cnt_q  <= clr_cnt_d;
            address_q  <= address_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
`ifdef OSD_TEXTWRITER_INVERSE_EN
            inv_q      <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        clr_cnt_d  = clr_cnt_q;
        address_d  = address_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        newline    = 1'b0;
`ifdef OSD_TEXTWRITER_INVERSE_EN
        inv_d      = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20) begin
                        address_d = {cursor_y_q, cursor_x_q};
`ifdef OSD_TEXTWRITER_INVERSE_EN
                        data_d    = {in_data[7] | inv_q, in_data[6:0]};
`else
                        data_d    = in_data;
`endif
                        wren_d    = 1'b1;
                        if (cursor_x_q != LAST_COL) begin
                            cursor_x_d = cursor_x_q + 5'd1;
                        end else begin
                            newline = 1'b1;
                        end
                    end else begin
                        case (in_data)
                            8'h0D: cursor_x_d = '0;
                            8'h0A: newline = 1'b1;
                            8'h08: begin
                                if (cursor_x_q != 5'd0) begin
                                    cursor_x_d = cursor_x_q - 5'd1;
                                end
                            end
                            8'h0C: begin
                                cursor_x_d = '0;
                                cursor_y_d = '0;
                                clr_cnt_d  = '0;
                                state_d    = CLR_ALL;
`ifdef OSD_TEXTWRITER_INVERSE_EN
                                inv_d      = 1'b0;
`endif
                            end
`ifdef OSD_TEXTWRITER_INVERSE_EN
                            8'h0E: inv_d = 1'b1;
                            8'h0F: inv_d = 1'b0;
`endif
                            default: ;
                        endcase
                    end
                end
                // Rows wrap from the bottom back to the top; there is no scrolling.
                if (newline) begin
                    cursor_x_d = '0;
                    cursor_y_d = (cursor_y_q == LAST_ROW) ? 3'd0 : cursor_y_q + 3'd1;
                    clr_cnt_d  = '0;
                    state_d    = CLR_ROW;
                end
            end
            CLR_ROW: begin
                address_d = {cursor_y_q, clr_cnt_q[4:0]};
                data_d    = blankData;
                wren_d    = 1'b1;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q[4:0] == LAST_COL) begin
                    state_d = IDLE;
                end
            end
            CLR_ALL: begin
                address_d = clr_cnt_q;
                data_d    = blankData;
                wren_d    = 1'b1;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign address  = address_q;
    assign data     = data_q;
    assign wren     = wren_q;
    assign cursor_x = cursor_x_q;
    assign cursor_y = cursor_y_q;

endmodule

// File: tb/tb_osd_textwriter.sv
// Self-checking bench for osd_textwriter: a queue-based model of expected buffer writes is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_osd_textwriter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] address;
    logic [7:0] data;
    logic       wren;
    logic [4:0] cursor_x;
    logic [2:0] cursor_y;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic ceMode = 1'b0;
    logic ceS, validS;
    logic [7:0] dataS;

    // Model state: cursor, inverse flag, and the pending clear writes still to be issued.
    int mx = 0;
    int my = 0;
    logic minv = 1'b0;
    logic [15:0] pend[$];
    logic expWren = 1'b0;
    logic [15:0] expWrite = '0;
    logic [15:0] logQ[$];
    int busyCnt = 0;

    osd_textwriter dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .address(address), .data(data), .wren(wren),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        ce = ceMode ? ~ce : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelNewline();
        mx = 0;
        my = (my + 1) % 8;
        for (int i = 0; i < 32; i++) pend.push_back({8'(my * 32 + i), 8'h20});
    endtask

    task automatic modelByte(input logic [7:0] b, output logic issued, output logic [15:0] w);
        issued = 1'b0;
        w = '0;
        if (b >= 8'h20) begin
            issued = 1'b1;
            w = {8'(my * 32 + mx), b | (minv ? 8'h80 : 8'h00)};
            if (mx < 31) mx++;
            else modelNewline();
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            modelNewline();
        end else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0C) begin
            mx = 0;
            my = 0;
            minv = 1'b0;
            for (int i = 0; i < 256; i++) pend.push_back({8'(i), 8'h20});
        end
`ifdef OSD_TEXTWRITER_INVERSE_EN
        else if (b == 8'h0E) minv = 1'b1;
        else if (b == 8'h0F) minv = 1'b0;
`endif
    endtask

    always @(negedge clk) begin
        ceS    = ce;
        validS = in_valid;
        dataS  = in_data;
    end

    // Per-cycle compare: advance the model on each ce edge, then check every output.
    always begin
        logic issued;
        logic [15:0] w;
        @(posedge clk);
        #1;
        if (reset) begin
            pend.delete();
            mx = 0;
            my = 0;
            minv = 1'b0;
            expWren = 1'b0;
            checkOutput("rstWren", wren, 0);
            checkOutput("rstCursor", {cursor_y, cursor_x}, 0);
            checkOutput("rstBusy", busy, 0);
        end else begin
            if (ceS) begin
                issued = 1'b0;
                w = '0;
                if (pend.size() > 0) begin
                    w = pend.pop_front();
                    issued = 1'b1;
                end else if (validS) begin
                    modelByte(dataS, issued, w);
                end
                expWren = issued;
                if (issued) expWrite = w;
                if (busy) busyCnt++;
            end
            checkOutput("wren", wren, expWren);
            if (expWren) checkOutput("write", {address, data}, expWrite);
            checkOutput("cursorX", cursor_x, mx);
            checkOutput("cursorY", cursor_y, my);
            checkOutput("busy", busy, pend.size() > 0);
            checkOutput("inReady", in_ready, pend.size() == 0);
            if (ceS && wren) logQ.push_back({address, data});
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        bit done = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (in_ready && ce) done = 1;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: byte 0x%0h not accepted", b);
        end
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clk);
            #2;
            if (in_ready && pend.size() == 0) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL idleTimeout: block never returned to idle");
        end
    endtask

    initial begin
        int bad;
        int logBefore;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        checkOutput("readyAfterReset", in_ready, 1);

        // Two characters back to back from the home position.
        logQ.delete();
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        waitIdle();
        checkOutput("firstWrite", logQ[0], 16'h0041);
        checkOutput("secondWrite", logQ[1], 16'h0142);
        checkOutput("abCursor", {cursor_y, cursor_x}, {3'd0, 5'd2});

        // Full row forces an autowrap and a clear of row 1.
        applyStimulus(8'h0D);
        logQ.delete();
        for (int i = 0; i < 32; i++) applyStimulus(8'(8'h40 + i));
        waitIdle();
        checkOutput("wrapLogSize", logQ.size(), 64);
        checkOutput("wrapLastChar", logQ[31], 16'h1F5F);
        bad = 0;
        for (int i = 0; i < 32; i++) if (logQ[32 + i] !== {8'(8'h20 + i), 8'h20}) bad++;
        checkOutput("rowClearSeq", bad, 0);
        checkOutput("wrapCursor", {cursor_y, cursor_x}, {3'd1, 5'd0});

        // Walk down to row 7, then LF wraps to row 0.
        for (int i = 0; i < 6; i++) applyStimulus(8'h0A);
        waitIdle();
        checkOutput("row7", cursor_y, 7);
        logQ.delete();
        busyCnt = 0;
        applyStimulus(8'h0A);
        waitIdle();
        checkOutput("lfWrapY", cursor_y, 0);
        checkOutput("lfLogSize", logQ.size(), 32);
        bad = 0;
        for (int i = 0; i < 32; i++) if (logQ[i] !== {8'(i), 8'h20}) bad++;
        checkOutput("lfClearSeq", bad, 0);
        checkOutput("lfBusyCycles", busyCnt, 32);

        // Form feed with a toggling clock enable.
        applyStimulus(8'h41);
        waitIdle();
        ceMode = 1'b1;
        logQ.delete();
        applyStimulus(8'h0C);
        waitIdle();
        ceMode = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("ffLogSize", logQ.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < logQ.size(); i++) if (logQ[i] !== {8'(i), 8'h20}) bad++;
        checkOutput("ffClearSeq", bad, 0);
        checkOutput("ffCursor", {cursor_y, cursor_x}, 0);
        checkOutput("ffReady", in_ready, 1);

        // Backspace and carriage return never write.
        for (int i = 0; i < 5; i++) applyStimulus(8'h61);
        waitIdle();
        @(posedge clk);
        #2;
        logBefore = logQ.size();
        applyStimulus(8'h08);
        checkOutput("bs1", cursor_x, 4);
        applyStimulus(8'h08);
        checkOutput("bs2", cursor_x, 3);
        applyStimulus(8'h0D);
        checkOutput("cr", cursor_x, 0);
        applyStimulus(8'h08);
        checkOutput("bsAtZero", cursor_x, 0);
        applyStimulus(8'h07);
        checkOutput("belIgnored", {cursor_y, cursor_x}, 0);
        waitIdle();
        checkOutput("noCtrlWrites", logQ.size(), logBefore);

`ifdef OSD_TEXTWRITER_INVERSE_EN
        logQ.delete();
        applyStimulus(8'h0E);
        applyStimulus(8'h41);
        applyStimulus(8'h0F);
        applyStimulus(8'h41);
        waitIdle();
        checkOutput("invOn", logQ[0], 16'h00C1);
        checkOutput("invOff", logQ[1], 16'h0141);
`endif

        // Reset in the middle of a screen clear aborts immediately.
        logQ.delete();
        applyStimulus(8'h0C);
        for (int i = 0; i < 400 && logQ.size() < 100; i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("ffCount100", logQ.size(), 100);
        reset = 1'b1;
        #1;
        checkOutput("abortWren", wren, 0);
        checkOutput("abortCursor", {cursor_y, cursor_x}, 0);
        checkOutput("abortBusy", busy, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("readyAfterAbort", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osd_textwriter.md
# osd_textwriter

Character-stream writer for the OSD text buffer: it takes bytes over a valid/ready handshake, keeps a cursor on the 32x8 text window, and drives the buffer write port (`address`/`data`/`wren`) of the text mode controller. It interprets a small set of control codes: CR, LF, BS and FF. It wraps the cursor, clears rows, and clears the whole screen with multi-cycle write loops. It sits between the OSD/menu logic (or the CPU-side OSD port) and the text mode controller.

## Interface
Parameters:
- `WINDOW_W`, 32: characters per row; fixed, must be a power of 2.
- `WINDOW_H`, 8: rows; fixed, must be a power of 2.
- `BLANK`, 8'h20: fill code used by row and screen clears.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; all state advances only on `clk` edges with `ce`=1.
- `in_data`  in  8  character or control byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this ce-cycle.
- `address`  out  8  text buffer write address, {row[2:0], col[4:0]}.
- `data`  out  8  text buffer write data; bit 7 selects the inverted glyph.
- `wren`  out  1  text buffer write strobe.
- `cursor_x`  out  5  current column.
- `cursor_y`  out  3  current row.
- `busy`  out  1  a clear loop is in progress (state CLR_ROW or CLR_ALL).

## Operation
States: IDLE, CLR_ROW, CLR_ALL. Registers: cursor_x, cursor_y, clr_cnt[7:0], inv.

- `in_ready` = (state==IDLE). A byte transfers on a ce-edge with `in_valid`&&`in_ready`.
- Printable byte (>=0x20, including 0x80..0xFF):
  - Writes `address`={cursor_y,cursor_x}, `data`=byte (bit 7 also ORed with `inv` when configured).
  - If cursor_x<31, cursor_x+1.
  - Otherwise perform a newline.
- 0x0D CR: cursor_x=0. No write.
- 0x0A LF: performs a newline.
- Newline:
  - cursor_x=0.
  - cursor_y=(cursor_y+1) mod 8; row 7 wraps to row 0 with no scrolling.
  - Enter CLR_ROW with clr_cnt=0.
- 0x08 BS: if cursor_x>0, cursor_x-1; at column 0 nothing happens. No write.
- 0x0C FF: cursor 0,0; clears inv; enters CLR_ALL with clr_cnt=0.
- Any other byte <0x20 is consumed and ignored.
- CLR_ROW:
  - Each ce-cycle writes `BLANK` at {cursor_y, clr_cnt[4:0]}.
  - After clr_cnt==31 the next state is IDLE.
- CLR_ALL:
  - Each ce-cycle writes `BLANK` at clr_cnt.
  - After clr_cnt==255 the next state is IDLE.
- All address arithmetic is modulo 256; counters wrap naturally.

## Timing
- Reset values:
  - `address`=0, `data`=0, `wren`=0.
  - `cursor_x`=0, `cursor_y`=0, `busy`=0, inv=0.
  - State IDLE, so `in_ready`=1 while reset is low.
- `address`/`data`/`wren` are registered.
  - A printable byte accepted at ce-edge k gives `wren`=1 from edge k to ce-edge k+1.
  - `wren` is cleared at edge k+1 unless a new write is issued there.
  - Back-to-back printable bytes give continuous `wren` with one write per ce-cycle.
- Cursor outputs update at the accepting edge.
- Newline or autowrap at edge k:
  - `busy`=1 and `in_ready`=0 from edge k.
  - Clear writes occupy ce-cycles k+1..k+32; for autowrap, the character write happens at k, first.
  - IDLE from edge k+32, so the next byte can be accepted at k+33.
- FF at edge k: writes occupy k+1..k+256; IDLE from edge k+256.
- When `ce`=0, all outputs hold, including `wren`.
- Reset asserted mid-clear: the loop aborts immediately, the buffer is left partially cleared, and the cursor returns to 0,0.

## Configuration
- `OSD_TEXTWRITER_INVERSE_EN` defined:
  - 0x0E (SO) sets inv; 0x0F (SI) clears inv.
  - Printable writes use `data`={byte[7]|inv, byte[6:0]}.
  - Clears always write `BLANK` with bit 7 = 0.
- Not defined: inv does not exist, 0x0E/0x0F are ignored like other control codes, and `data`=byte.

## Test plan
- After reset, send 0x41,0x42 -> writes 0x41@0x00 and 0x42@0x01 on consecutive ce-cycles; cursor_x=2, cursor_y=0.
- Send 32 printable bytes at row 0 -> last write @0x1F; then 32 writes of 0x20 at 0x20..0x3F with `in_ready`=0; then cursor=(0,1).
- With cursor_y=7, send LF -> cursor_y=0; writes 0x20@0x00..0x1F; `busy` high for exactly 32 ce-cycles.
- Send FF with `ce` toggling 1/0 -> 256 writes at 0x00..0xFF with no skips or duplicates; cursor 0,0; `in_ready` returns after the last write.
- Cursor x=5: send BS,BS,CR,BS -> cursor_x 4,3,0,0; no `wren`. Send 0x07 -> ignored.
- With the macro defined, send 0x0E,0x41,0x0F,0x41 -> data 0xC1 then 0x41. Assert reset during FF at count 100 -> `wren`=0 and cursor 0,0 at once.
